// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: FSM states, forwarding selects
// and the number of advance cycles needed to drain the pipe behind a HALT.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10,
        ST_PAUSE  = 2'b11
    } state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam int         DRAIN_CYCLES = 3;
    localparam logic [1:0] DRAIN_LOAD   = 2'(DRAIN_CYCLES);

endpackage

// File: rtl/forward_sel.sv
// Forwarding select for one ALU operand; EX/MEM wins over MEM/WB and
// register 0 is never forwarded.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic       mem_write,
    input  logic [4:0] mem_reg,
    input  logic       wb_write,
    input  logic [4:0] wb_reg,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_NONE;
        if (mem_write && (mem_reg != 5'd0) && (mem_reg == src_reg)) begin
            sel = FWD_MEM;
        end else if (wb_write && (wb_reg != 5'd0) && (wb_reg == src_reg)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: operand forwarding, load-use stall, HALT drain and
// debug single-step. Define HAZARD_STATS_EN to include the load-use stall counter.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal execution, pipeline advances every cycle
// DRAIN  | HALT accepted in ID; let older instructions retire, no fetch
// HALTED | all pipeline registers frozen until reset
// PAUSE  | debug mode, pipeline advances only on i_step
module hazard_control
    import hazard_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_debug_mode,
    input  logic        i_step,
    input  logic        i_id_halt,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic [4:0]  i_ex_rs,
    input  logic [4:0]  i_ex_rt,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_write_reg,
    input  logic        i_mem_wb_write,
    input  logic [4:0]  i_mem_write_reg,
    input  logic        i_wb_write,
    input  logic [4:0]  i_wb_write_reg,
    output logic [1:0]  o_corto_rs,
    output logic [1:0]  o_corto_rt,
    output logic        o_stall,
    output logic        o_halt,
    output logic        o_halted,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_count
);

    state_t     state;
    state_t     state_next;
    logic [1:0] drain_cnt;
    logic [1:0] drain_cnt_next;
    logic       load_use;

    forward_sel u_fwd_rs (
        .src_reg   (i_ex_rs),
        .mem_write (i_mem_wb_write),
        .mem_reg   (i_mem_write_reg),
        .wb_write  (i_wb_write),
        .wb_reg    (i_wb_write_reg),
        .sel       (o_corto_rs)
    );

    forward_sel u_fwd_rt (
        .src_reg   (i_ex_rt),
        .mem_write (i_mem_wb_write),
        .mem_reg   (i_mem_write_reg),
        .wb_write  (i_wb_write),
        .wb_reg    (i_wb_write_reg),
        .sel       (o_corto_rt)
    );

    // A HALT in ID takes precedence over a load-use bubble so it is accepted at once.
    assign load_use = i_ex_mem_read
                    && (i_ex_write_reg != 5'd0)
                    && ((i_ex_write_reg == i_id_rs) || (i_ex_write_reg == i_id_rt))
                    && !i_id_halt
                    && ((state == ST_RUN) || (state == ST_PAUSE));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_RUN;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            ST_RUN: begin
                if (i_debug_mode) begin
                    state_next = ST_PAUSE;
                end else if (i_id_halt && !o_halt && !o_stall) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            ST_PAUSE: begin
                if (!i_debug_mode) begin
                    state_next = ST_RUN;
                end else if (i_step && i_id_halt && !o_stall) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!o_halt) begin
                    drain_cnt_next = drain_cnt - 2'd1;
                    if (drain_cnt == 2'd1) begin
                        state_next = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next     = ST_RUN;
                drain_cnt_next = 2'd0;
            end
        endcase
    end

    always_comb begin
        o_stall = 1'b0;
        o_halt  = 1'b0;
        case (state)
            ST_RUN: begin
                o_stall = load_use;
            end
            ST_PAUSE: begin
                o_stall = load_use;
                o_halt  = !i_step;
            end
            ST_DRAIN: begin
                o_stall = 1'b1;
                o_halt  = i_debug_mode && !i_step;
            end
            ST_HALTED: begin
                o_halt = 1'b1;
            end
            default: begin
                o_stall = 1'b0;
                o_halt  = 1'b0;
            end
        endcase
    end

    assign o_halted = (state == ST_HALTED);
    assign o_state  = state;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_count_q <= 32'd0;
        end else if (load_use && (stall_count_q != 32'hffff_ffff)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign o_stall_count = stall_count_q;
`else
    assign o_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the controller.
module tb_hazard_control;

    logic        i_clk;
    logic        i_reset;
    logic        i_debug_mode;
    logic        i_step;
    logic        i_id_halt;
    logic [4:0]  i_id_rs;
    logic [4:0]  i_id_rt;
    logic [4:0]  i_ex_rs;
    logic [4:0]  i_ex_rt;
    logic        i_ex_mem_read;
    logic [4:0]  i_ex_write_reg;
    logic        i_mem_wb_write;
    logic [4:0]  i_mem_write_reg;
    logic        i_wb_write;
    logic [4:0]  i_wb_write_reg;
    logic [1:0]  o_corto_rs;
    logic [1:0]  o_corto_rt;
    logic        o_stall;
    logic        o_halt;
    logic        o_halted;
    logic [1:0]  o_state;
    logic [31:0] o_stall_count;

    hazard_control dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_debug_mode    (i_debug_mode),
        .i_step          (i_step),
        .i_id_halt       (i_id_halt),
        .i_id_rs         (i_id_rs),
        .i_id_rt         (i_id_rt),
        .i_ex_rs         (i_ex_rs),
        .i_ex_rt         (i_ex_rt),
        .i_ex_mem_read   (i_ex_mem_read),
        .i_ex_write_reg  (i_ex_write_reg),
        .i_mem_wb_write  (i_mem_wb_write),
        .i_mem_write_reg (i_mem_write_reg),
        .i_wb_write      (i_wb_write),
        .i_wb_write_reg  (i_wb_write_reg),
        .o_corto_rs      (o_corto_rs),
        .o_corto_rt      (o_corto_rt),
        .o_stall         (o_stall),
        .o_halt          (o_halt),
        .o_halted        (o_halted),
        .o_state         (o_state),
        .o_stall_count   (o_stall_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain flags and a remaining-advance count.
    bit      m_paused;
    bit      m_draining;
    bit      m_halted;
    int      m_left;
    longint  m_stalls;
    bit      stats_on;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (i_mem_wb_write && i_mem_write_reg != 0 && i_mem_write_reg == src) return 2'd2;
        if (i_wb_write && i_wb_write_reg != 0 && i_wb_write_reg == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] state_model();
        if (m_halted) return 2'd2;
        if (m_draining) return 2'd1;
        if (m_paused) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [31:0] count_model();
        if (!stats_on) return 32'd0;
        return 32'(m_stalls);
    endfunction

    task automatic model_reset();
        m_paused   = 0;
        m_draining = 0;
        m_halted   = 0;
        m_left     = 0;
        m_stalls   = 0;
    endtask

    // Called with inputs already driven just after a falling edge; checks all
    // outputs against the model, then advances the model across the rising edge.
    task automatic tick();
        bit lu, e_stall, e_halt;
        #1;
        lu = i_ex_mem_read && i_ex_write_reg != 0
             && (i_ex_write_reg == i_id_rs || i_ex_write_reg == i_id_rt)
             && !i_id_halt && !m_draining && !m_halted;
        e_stall = m_draining ? 1'b1 : lu;
        if (m_halted)        e_halt = 1;
        else if (m_draining) e_halt = i_debug_mode && !i_step;
        else if (m_paused)   e_halt = !i_step;
        else                 e_halt = 0;
        check("corto_rs", 32'(o_corto_rs), 32'(fwd_model(i_ex_rs)));
        check("corto_rt", 32'(o_corto_rt), 32'(fwd_model(i_ex_rt)));
        check("stall", 32'(o_stall), 32'(e_stall));
        check("halt", 32'(o_halt), 32'(e_halt));
        check("state", 32'(o_state), 32'(state_model()));
        check("halted", 32'(o_halted), 32'(m_halted));
        check("stall_count", o_stall_count, count_model());
        @(posedge i_clk);
        if (lu && m_stalls < 64'h0000_0000_ffff_ffff) m_stalls++;
        if (m_halted) begin
        end else if (m_draining) begin
            if (!e_halt) begin
                m_left--;
                if (m_left == 0) begin
                    m_draining = 0;
                    m_halted   = 1;
                end
            end
        end else if (m_paused) begin
            if (!i_debug_mode) m_paused = 0;
            else if (i_step && i_id_halt) begin
                m_paused   = 0;
                m_draining = 1;
                m_left     = 3;
            end
        end else begin
            if (i_debug_mode) m_paused = 1;
            else if (i_id_halt) begin
                m_draining = 1;
                m_left     = 3;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_debug_mode    = 0;
        i_step          = 0;
        i_id_halt       = 0;
        i_id_rs         = 0;
        i_id_rt         = 0;
        i_ex_rs         = 0;
        i_ex_rt         = 0;
        i_ex_mem_read   = 0;
        i_ex_write_reg  = 0;
        i_mem_wb_write  = 0;
        i_mem_write_reg = 0;
        i_wb_write      = 0;
        i_wb_write_reg  = 0;
    endtask

    // Reset lands between clock edges; outputs must react before any edge.
    task automatic do_reset();
        #2 i_reset = 1;
        #1;
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_halt", 32'(o_halt), 32'd0);
        check("rst_halted", 32'(o_halted), 32'd0);
        check("rst_count", o_stall_count, 32'd0);
        model_reset();
        @(negedge i_clk);
        i_reset = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] saved;
`ifdef HAZARD_STATS_EN
        stats_on = 1;
`else
        stats_on = 0;
`endif
        clear_inputs();
        model_reset();
        i_reset = 1;
        @(negedge i_clk);
        i_reset = 0;
        do_reset();

        // Forwarding priority and register 0
        i_mem_wb_write = 1; i_mem_write_reg = 5; i_wb_write = 1; i_wb_write_reg = 5; i_ex_rs = 5;
        #1 check("fwd_mem_prio", 32'(o_corto_rs), 32'd2);
        tick();
        i_mem_wb_write = 0;
        #1 check("fwd_wb", 32'(o_corto_rs), 32'd1);
        tick();
        i_mem_wb_write = 1; i_mem_write_reg = 0; i_wb_write_reg = 0; i_ex_rt = 0;
        #1 check("fwd_r0", 32'(o_corto_rt), 32'd0);
        tick();

        // Load-use stall for one cycle
        clear_inputs();
        i_ex_mem_read = 1; i_ex_write_reg = 6; i_id_rt = 6;
        #1 check("lu_stall", 32'(o_stall), 32'd1);
        tick();
        i_ex_mem_read = 0;
        #1 check("lu_release", 32'(o_stall), 32'd0);
        check("lu_count", o_stall_count, stats_on ? 32'd1 : 32'd0);
        tick();

        // HALT drain in RUN
        i_id_halt = 1;
        tick();
        i_id_halt = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check("drain_state", 32'(o_state), 32'd1);
            check("drain_stall", 32'(o_stall), 32'd1);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            #1 check("halted_state", 32'(o_state), 32'd2);
            check("halted_halt", 32'(o_halt), 32'd1);
            check("halted_flag", 32'(o_halted), 32'd1);
            i_step = (i % 2 == 0);
            tick();
        end
        i_step = 0;
        do_reset();

        // Debug stepping into HALT
        i_debug_mode = 1;
        tick();
        #1 check("pause_state", 32'(o_state), 32'd3);
        check("pause_halt", 32'(o_halt), 32'd1);
        i_id_halt = 1;
        for (int p = 1; p <= 4; p++) begin
            i_step = 1;
            tick();
            i_step = 0;
            i_id_halt = 0;
            tick();
            #1 check("step_state", 32'(o_state), (p == 4) ? 32'd2 : 32'd1);
        end
        clear_inputs();
        do_reset();

        // Load-use coinciding with HALT
        i_ex_mem_read = 1; i_ex_write_reg = 6; i_id_rt = 6; i_id_halt = 1;
        #1 check("lu_halt_stall", 32'(o_stall), 32'd0);
        saved = o_stall_count;
        tick();
        clear_inputs();
        #1 check("lu_halt_state", 32'(o_state), 32'd1);
        check("lu_halt_count", o_stall_count, saved);
        tick();

        // Async reset mid-drain (counter at 2 after one advance)
        do_reset();
        i_id_halt = 1;
        tick();
        i_id_halt = 0;
        tick();
        do_reset();

        // Random stimulus
        for (int n = 0; n < 3000; n++) begin
            i_id_rs         = 5'($urandom_range(0, 7));
            i_id_rt         = 5'($urandom_range(0, 7));
            i_ex_rs         = 5'($urandom_range(0, 7));
            i_ex_rt         = 5'($urandom_range(0, 7));
            i_ex_mem_read   = 1'($urandom_range(0, 1));
            i_ex_write_reg  = 5'($urandom_range(0, 7));
            i_mem_wb_write  = 1'($urandom_range(0, 1));
            i_mem_write_reg = 5'($urandom_range(0, 7));
            i_wb_write      = 1'($urandom_range(0, 1));
            i_wb_write_reg  = 5'($urandom_range(0, 7));
            i_id_halt       = ($urandom_range(0, 15) == 0);
            i_step          = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) i_debug_mode = ~i_debug_mode;
            tick();
            if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
                do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
